// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared types and defaults for the POV column scheduler
package pov_pkg;

  localparam int COL_W_DEF    = 4;
  localparam int NUM_COLS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pov_sync_edge.sv
// rtl/pov_sync_edge.sv - 2-flop synchronizer with rising-edge detect for async sensor levels
module pov_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic q1, q2, q3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= din;
      q2 <= q1;
      q3 <= q2;
    end
  end

  assign rise = q2 & ~q3;

endmodule

// File: rtl/pov_column_sched.sv
// rtl/pov_column_sched.sv - POV column scheduler, initiator of the start/done handshake
// Optional WAIT watchdog enabled by defining POV_WATCHDOG_EN.
module pov_column_sched
  import pov_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF,
  parameter int COL_W    = COL_W_DEF,
  parameter int WD_LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_in,
  input  logic             done_in,
  output logic             start_out,
  output logic [COL_W-1:0] col_idx,
  output logic             col_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       resync_cnt,
  output logic             timeout_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  state_t           state, state_n;
  logic [COL_W-1:0] col_n;
  logic             sync_rise;
  logic             resync;
  logic             wd_fire;
  logic             wd_abort;

  pov_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sync_in),
    .rise (sync_rise)
  );

`ifdef POV_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT + 1);
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_fire = (state == WAIT) && (wd_cnt == WD_W'(WD_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           timeout_err <= 1'b0;
    else if (wd_abort) timeout_err <= 1'b1;
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    col_n    = col_idx;
    resync   = 1'b0;
    wd_abort = 1'b0;
    // A mid-frame index pulse restarts the frame and outranks done_in.
    if (sync_rise && state != IDLE) begin
      resync  = 1'b1;
      col_n   = '0;
      state_n = ARM;
    end else begin
      case (state)
        IDLE: begin
          if (sync_rise) begin
            col_n   = '0;
            state_n = ARM;
          end
        end
        ARM: state_n = WAIT;
        WAIT: begin
          if (done_in) begin
            if (col_idx == LAST_COL) begin
              state_n = DONE;
            end else begin
              col_n   = col_idx + 1'b1;
              state_n = ARM;
            end
          end else if (wd_fire) begin
            wd_abort = 1'b1;
            state_n  = IDLE;
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col_idx    <= '0;
      resync_cnt <= '0;
    end else begin
      state   <= state_n;
      col_idx <= col_n;
      if (resync && resync_cnt != 8'hFF) resync_cnt <= resync_cnt + 1'b1;
    end
  end

  assign start_out  = (state == ARM);
  assign busy       = (state != IDLE);
  assign col_valid  = (state == ARM) || (state == WAIT);
  assign frame_done = (state == DONE);

endmodule

// File: doc/pov_column_sched.md
# pov_column_sched

Column scheduler for the persistence-of-vision display: on each rotation index pulse it walks the column index from 0 to NUM_COLS-1. For each column it fires a one-cycle start request to the per-column delay counter and waits for that counter's one-cycle done pulse before advancing. It is the initiator end of the start/done handshake. It drives the column address seen by the LED pattern logic.

## Interface
- NUM_COLS, 16: columns per rotation frame (2..2**COL_W)
- COL_W, 4: width of column index
- WD_LIMIT, 64: max cycles in WAIT before abort (watchdog build only)
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- sync_in  in  1  rotation index (hall sensor), asynchronous level
- done_in  in  1  one-cycle done pulse from delay counter
- start_out  out  1  one-cycle start request to delay counter
- col_idx  out  COL_W  current column
- col_valid  out  1  col_idx is being displayed
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse, last column completed
- resync_cnt  out  8  count of frames restarted by sync mid-frame, saturating at 255
- timeout_err  out  1  sticky watchdog abort flag

## Operation
- sync_in passes through a 2-flop synchronizer (q1, q2), then q3 = prior q2. sync_rise = q2 & ~q3.
- FSM states: IDLE, ARM, WAIT, DONE. Outputs are Moore, decoded from registered state and col_idx.
- IDLE: busy=0, col_valid=0. On sync_rise: col_idx<=0, go to ARM.
- ARM: start_out=1, busy=1, col_valid=1. Unconditionally go to WAIT next edge. done_in is ignored in ARM.
- WAIT: busy=1, col_valid=1. On done_in:
  - if col_idx==NUM_COLS-1, go to DONE;
  - else col_idx<=col_idx+1 and go to ARM.
- DONE: frame_done=1, busy=1, col_valid=0. Go to IDLE next edge.
- sync_rise in ARM, WAIT or DONE (mid-frame resync):
  - col_idx<=0, go to ARM;
  - resync_cnt increments and holds at 255;
  - sync_rise has priority over a simultaneous done_in.
- done_in in IDLE or DONE is ignored.
- col_idx never exceeds NUM_COLS-1; there is no wrap inside a frame.

## Timing
- Reset values: state=IDLE, sync flops=0, col_idx=0, start_out=0, col_valid=0, busy=0, frame_done=0, resync_cnt=0, timeout_err=0.
- Reset asserted mid-frame returns to IDLE immediately (asynchronous), with no frame_done.
- sync_in first sampled high at edge k: sync_rise is valid after edge k+1, state=ARM after edge k+2, start_out high for the cycle after k+2.
- done_in sampled at edge m in WAIT: state=ARM after edge m, with start_out high in the following cycle (1-cycle turnaround).
- start_out is never high on two consecutive cycles.
- A full frame with zero-delay done takes 2*NUM_COLS+1 cycles from the first ARM to the end of DONE.

## Configuration
- POV_WATCHDOG_EN defined:
  - a counter clears on entering WAIT and increments each WAIT cycle;
  - reaching WD_LIMIT without done_in sets timeout_err (sticky until rst) and forces IDLE, with col_valid=0 and no frame_done;
  - a done_in on the same cycle the limit is reached wins.
- POV_WATCHDOG_EN undefined: WAIT persists indefinitely, no counter logic exists, and timeout_err is tied 0.

## Structure
- Shared package pov_pkg holds the state enum type (IDLE/ARM/WAIT/DONE) and the default COL_W/NUM_COLS constants.
- Sub-module pov_sync_edge: 2-flop synchronizer plus rising-edge detect, with async reset to 0. It is reusable for other sensor inputs.

## Test plan
- NUM_COLS=4; sync_in pulse; done_in returned 3 cycles after each start_out → col_idx 0,1,2,3 each with one start_out, then frame_done once, then busy=0.
- Reset asserted while in WAIT at col_idx=2 → all outputs at reset values within the same cycle; a later done_in is ignored.
- sync_rise and done_in on the same edge in WAIT at col_idx=1 → col_idx=0, state=ARM, resync_cnt=1.
- 300 mid-frame resyncs → resync_cnt=255 and holds.
- POV_WATCHDOG_EN with WD_LIMIT=8 and done_in withheld → timeout_err=1 after 8 WAIT cycles, state IDLE, no frame_done; a new sync_in starts a frame with timeout_err still 1.
- Spurious done_in in IDLE and in ARM → no start_out and col_idx unchanged.
